// File: rtl/sshooter_lpf_pkg.sv
// Shared types, coefficient table and helpers for the SSG low-pass scheduler.
package sshooter_lpf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    WB,
    COMMIT
  } state_t;

  typedef struct packed {
    logic signed [17:0] a2;
    logic signed [17:0] b1;
    logic signed [17:0] b2;
  } coef_t;

  // Entry 0 is bypass: B1 = 1.0 in Q15, no feedback, so y = x through the same MAC path.
  localparam coef_t COEF_TBL [4] = '{
    '{a2: 18'sd0,      b1: 18'sd32768, b2: 18'sd0},
    '{a2: -18'sd32244, b1: 18'sd262,   b2: 18'sd262},
    '{a2: -18'sd31130, b1: 18'sd819,   b2: 18'sd819},
    '{a2: -18'sd28672, b1: 18'sd2048,  b2: 18'sd2048}
  };

  localparam logic signed [37:0] ROUND = 38'sd16384;
  localparam int unsigned        SHIFT = 15;

  function automatic logic signed [15:0] sat16(input logic signed [37:0] v);
    if (v > 38'sd32767) begin
      return 16'sh7fff;
    end else if (v < -38'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/sshooter_lpf_mac.sv
// Shared 18x18 multiplier, 38-bit accumulator and Q15 round/saturate stage.
module sshooter_lpf_mac
  import sshooter_lpf_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_add,
  input  logic signed [17:0] i_a,
  input  logic signed [17:0] i_b,
  output logic signed [15:0] o_y
);

  logic signed [35:0] w_prod;
  logic signed [37:0] w_rnd;
  logic signed [37:0] r_acc;

  // Product of the currently selected operands and the rounded result of the accumulator.
  always_comb begin
    w_prod = 36'(i_a) * 36'(i_b);
    w_rnd  = (r_acc + ROUND) >>> SHIFT;
    o_y    = sat16(w_rnd);
  end

  // Accumulator: load starts a new sum, add extends it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= 38'(w_prod);
    end else if (i_add) begin
      r_acc <= r_acc + 38'(w_prod);
    end
  end

endmodule

// File: rtl/sshooter_lpf_sched.sv
// Time-multiplexed biquad-style low-pass filter for NCH SSG channels.
// done is high during the COMMIT cycle; ch_out/mix_out load on its closing edge.
module sshooter_lpf_sched
  import sshooter_lpf_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int MIN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            div,
  input  logic [NCH-1:0][15:0]  ch_in,
  input  logic [NCH-1:0][1:0]   fsel,
  output logic [NCH-1:0][15:0]  ch_out,
  output logic signed [15:0]    mix_out,
  output logic                  busy,
  output logic                  done
);

  localparam int             CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int             SW      = 16 + $clog2(NCH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic [9:0]     MIN_D   = 10'(MIN_DIV);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [9:0]           r_cnt;
  logic [9:0]           w_d;
  logic                 w_tick;
  logic                 w_start;
  logic [CHW-1:0]       r_ch;
  logic signed [15:0]   r_x      [NCH];
  logic [1:0]           r_sel    [NCH];
  logic signed [15:0]   r_xp     [NCH];
  logic signed [15:0]   r_yp     [NCH];
  logic signed [15:0]   r_shadow [NCH];
  logic [NCH-1:0][15:0] r_ch_out;
  logic signed [15:0]   r_mix;
  coef_t                w_coef;
  logic                 w_load;
  logic                 w_add;
  logic signed [17:0]   w_a;
  logic signed [17:0]   w_b;
  logic signed [15:0]   w_y;
  logic signed [SW-1:0] w_sum;
  logic signed [15:0]   w_mix;

  // Effective divider and tick; a counter already past D-1 ticks at once.
  always_comb begin
    w_d     = (div > MIN_D) ? div : MIN_D;
    w_tick  = (r_cnt >= w_d - 10'd1);
    w_start = (r_state == IDLE) && w_tick;
  end

  // Free-running sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

  // Next state and MAC operand selection for the current channel.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_coef      = COEF_TBL[r_sel[r_ch]];
    case (r_state)
      IDLE: begin
        if (w_tick) w_state_nxt = MAC0;
      end
      MAC0: begin
        w_load      = 1'b1;
        w_a         = w_coef.b1;
        w_b         = {{2{r_x[r_ch][15]}}, r_x[r_ch]};
        w_state_nxt = MAC1;
      end
      MAC1: begin
        w_add       = 1'b1;
        w_a         = w_coef.b2;
        w_b         = {{2{r_xp[r_ch][15]}}, r_xp[r_ch]};
        w_state_nxt = MAC2;
      end
      MAC2: begin
        w_add       = 1'b1;
        w_a         = -w_coef.a2;
        w_b         = {{2{r_yp[r_ch][15]}}, r_yp[r_ch]};
        w_state_nxt = WB;
      end
      WB: begin
        w_state_nxt = (r_ch == LAST_CH) ? COMMIT : MAC0;
      end
      COMMIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and channel index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        r_ch <= '0;
      end else if ((r_state == WB) && (r_ch != LAST_CH)) begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

  // Input holding registers, loaded only when a sequence starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_x[i]   <= '0;
        r_sel[i] <= '0;
      end
    end else if (w_start) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_x[i]   <= ch_in[i];
        r_sel[i] <= fsel[i];
      end
    end
  end

  // Write-back of the filtered sample and the per-channel history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_xp[i]     <= '0;
        r_yp[i]     <= '0;
        r_shadow[i] <= '0;
      end
    end else if (r_state == WB) begin
      r_shadow[r_ch] <= w_y;
      r_xp[r_ch]     <= r_x[r_ch];
      r_yp[r_ch]     <= w_y;
    end
  end

  // Saturated mix of the completed shadow set.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_sum = w_sum + SW'(r_shadow[i]);
    end
    w_mix = sat16(38'(w_sum));
  end

  // Output registers, all updated together at COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_out <= '0;
      r_mix    <= '0;
    end else if (r_state == COMMIT) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_ch_out[i] <= r_shadow[i];
      end
      r_mix <= w_mix;
    end
  end

  assign ch_out  = r_ch_out;
  assign mix_out = r_mix;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == COMMIT);

  sshooter_lpf_mac u_mac (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_add   (w_add),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_y     (w_y)
  );

endmodule

// File: doc/sshooter_lpf_sched.md
SSHOOTER_LPF_SCHED -- requirements
Module: sshooter_lpf_sched

Interface
REQ-001 The block SHALL have parameter NCH, default 3, meaning the number of SSG channels filtered.
REQ-002 The block SHALL have parameter MIN_DIV, default 16, meaning the smallest effective sample divider.
REQ-003 Port clk, input, 1, is the single system clock (49.152 MHz).
REQ-004 Port reset, input, 1, is the reset; synchronous, active-high.
REQ-005 Port div, input, 10, is the sample-rate divider in clk cycles.
REQ-006 Port ch_in, input, NCH x 16 signed, carries the per-channel SSG samples.
REQ-007 Port fsel, input, NCH x 2, is the per-channel filter select latched from the sound CPU: 0 = bypass, 1..3 = coefficient set.
REQ-008 Port ch_out, output, NCH x 16 signed, carries the filtered per-channel samples.
REQ-009 Port mix_out, output, 16 signed, carries the saturated sum of ch_out.
REQ-010 Port busy, output, 1, is high while the sequencer is running.
REQ-011 Port done, output, 1, is a one-cycle pulse when all outputs update.

Function
REQ-012 The sample counter SHALL count 0..D-1 and then wrap, with D = max(div, MIN_DIV); the cycle where count = D-1 is the tick.
REQ-013 If div changes so that count >= D-1, the tick SHALL occur on the next cycle and the counter SHALL wrap to 0.
REQ-014 On tick, the block SHALL capture all ch_in and fsel into holding registers; values that change later SHALL NOT affect the running sequence.
REQ-015 FSM states SHALL be IDLE, MAC0, MAC1, MAC2, WB, COMMIT. A tick moves IDLE to MAC0 with ch = 0.
REQ-016 MAC0 SHALL compute acc = B1*x.
REQ-017 MAC1 SHALL compute acc += B2*xp.
REQ-018 MAC2 SHALL compute acc += (-A2)*yp.
REQ-019 WB SHALL compute y = sat16((acc + 2^14) >>> 15) and write it to the shadow register, then set xp <= x and yp <= y.
REQ-020 After WB, the FSM SHALL go to MAC0 with ch+1 if ch < NCH-1, else to COMMIT.
REQ-021 COMMIT SHALL copy the shadows to ch_out simultaneously, update mix_out, pulse done, and return to IDLE.
REQ-022 Exactly one shared 18x18 signed multiplier SHALL serve all channels and all three terms.
REQ-023 The accumulator SHALL be 38-bit signed; the three products SHALL be summed without overflow.
REQ-024 With fsel = 0 the channel SHALL still use 4 cycles, with y = x; xp and yp SHALL still update so a later filter switch starts from current history.
REQ-025 Coefficients (A2, B1 = B2) SHALL be selected from the latched fsel:
- set 1 = (-32244, 262)
- set 2 = (-31130, 819)
- set 3 = (-28672, 2048)
REQ-026 Latency SHALL be fixed: tick at cycle T, then MAC/WB over T+1..T+4*NCH, and COMMIT/done at T+4*NCH+1.
REQ-027 busy SHALL be high from T+1 through T+4*NCH+1 inclusive.
REQ-028 mix_out SHALL be the sum of ch_out over a width of 16+clog2(NCH) bits, saturated to [-32768, 32767].
REQ-029 MIN_DIV SHALL be at least 4*NCH+2, so a tick never arrives while busy.
REQ-030 If a tick ever arrives while busy, it SHALL be ignored.

Reset
REQ-031 While reset is high, the counter, FSM (to IDLE), acc, shadows, xp, yp, ch_out, mix_out, busy and done SHALL all be cleared to 0 on the next clk edge.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence with no COMMIT; the first tick after release SHALL occur D cycles after reset deasserts.

Structure
REQ-033 Package sshooter_lpf_pkg SHALL hold the FSM state enum, the coefficient struct {A2, B1, B2} (18-bit signed each), the 4-entry coefficient table, and the constants ROUND = 2^14 and SHIFT = 15.
REQ-034 One sub-module, sshooter_lpf_mac, SHALL contain the shared multiplier, the accumulator and the round/saturate stage; the FSM and the counter SHALL live in the top level.

Verification
REQ-035 Bypass, step: reset; div = 256; fsel = 0 on all channels; ch_in = 1000 -> after the first tick, done at T+13 and ch_out = 1000 on all channels.
REQ-036 Filter step: fsel[0] = 1, ch_in[0] = 16384 from reset.
- First output = round(16384*262/32768) = 131.
- Output rises monotonically toward 16384 and stays within ±2 after 2000 ticks.
REQ-037 Saturation: fsel = 3; ch_in = +32767 held on all channels -> each ch_out <= 32767; mix_out = 32767 (saturated).
- With ch_in = -32768 on all channels -> mix_out = -32768.
REQ-038 Divider clamp and latching:
- div = 5 -> ticks every 16 cycles, busy never overlaps a tick.
- Toggling fsel and ch_in during busy -> output matches a reference model using the values latched at tick.
REQ-039 Reset mid-operation: assert reset at T+6 -> no done pulse; all outputs 0.
- After release, the first done occurs D+13 cycles later and matches a fresh-state model.
